// File: rtl/spi_minion_packet_adapter.sv
// SPI minion front-end: oversamples the SPI pins, deframes fixed-length transfers into val/rdy
// packets and serializes buffered responses onto MISO. Sticky error flag built only with SPI_MINION_PARITY_EN.
module spi_minion_packet_adapter #(
    parameter int BIT_WIDTH  = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_cs,
    input  logic                 spi_sclk,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic [BIT_WIDTH-1:0] send_msg,
    output logic                 send_val,
    input  logic                 send_rdy,
    input  logic [BIT_WIDTH-1:0] recv_msg,
    input  logic                 recv_val,
    output logic                 recv_rdy,
    output logic                 parity
);

    localparam int FW = BIT_WIDTH + 2;
    localparam int CW = $clog2(BIT_WIDTH + 4);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] FRAME_BITS = CW'(FW);
    localparam logic [CW-1:0] CNT_MAX    = CW'(FW + 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   LVL_ONE    = (AW + 1)'(1);
    localparam logic [AW:0]   LVL_FULL   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_FRAME
    } state_e;

    state_e state_q, state_d;

    logic [1:0] cs_sync, sclk_sync, mosi_sync;
    logic       cs_prev, sclk_prev;
    logic       cs_s, sclk_s, mosi_s;
    logic       cs_rise, cs_fall, sclk_rise, sclk_fall;
    logic       frame_start, frame_end, frame_active, frame_ok;

    logic [CW-1:0] bit_cnt;
    logic [FW-1:0] rx_shift, tx_shift;
    logic          rvalid_cap;
    logic          wflag, rflag;
    logic [BIT_WIDTH-1:0] payload;

    logic [BIT_WIDTH-1:0] send_mem [FIFO_DEPTH];
    logic [AW-1:0]        send_wr, send_rd;
    logic [AW:0]          send_lvl;
    logic                 send_full, send_empty, send_push, send_pop;

    logic [BIT_WIDTH-1:0] resp_mem [FIFO_DEPTH];
    logic [AW-1:0]        resp_wr, resp_rd;
    logic [AW:0]          resp_lvl;
    logic                 resp_full, resp_empty, resp_push, resp_pop;
    logic [BIT_WIDTH-1:0] resp_head;
    logic                 rdy_en;

    // Reset value 0 on the cs path means a fall can only be seen after cs has been observed high.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
            cs_sync   <= '0;
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_prev   <= 1'b0;
            sclk_prev <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[0], spi_cs};
            sclk_sync <= {sclk_sync[0], spi_sclk};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            cs_prev   <= cs_sync[1];
            sclk_prev <= sclk_sync[1];
        end
    end

    assign cs_s      = cs_sync[1];
    assign sclk_s    = sclk_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign cs_rise   = cs_s & ~cs_prev;
    assign cs_fall   = ~cs_s & cs_prev;
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d     = state_q;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    frame_start = 1'b1;
                    state_d     = ST_FRAME;
                end
            end
            ST_FRAME: begin
                if (cs_rise) begin
                    frame_end = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign frame_active = (state_q == ST_FRAME) && !cs_s;

    // Shift datapath; MISO is the TX MSB, so it only moves on frame start and sclk falls.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            rvalid_cap <= 1'b0;
        end else if (frame_start) begin
            bit_cnt    <= '0;
            tx_shift   <= {~send_full, ~resp_empty, resp_head};
            rvalid_cap <= ~resp_empty;
        end else if (frame_active) begin
            if (sclk_rise) begin
                rx_shift <= {rx_shift[FW-2:0], mosi_s};
                if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + CNT_ONE;
            end
            if (sclk_fall) tx_shift <= {tx_shift[FW-2:0], 1'b0};
        end
    end

    assign spi_miso = tx_shift[FW-1];

    assign wflag    = rx_shift[FW-1];
    assign rflag    = rx_shift[FW-2];
    assign payload  = rx_shift[BIT_WIDTH-1:0];
    assign frame_ok = frame_end && (bit_cnt == FRAME_BITS);

    // rvalid_cap guarantees the response FIFO still holds the entry that was shifted out.
    assign send_push = frame_ok && wflag && !send_full;
    assign resp_pop  = frame_ok && rflag && rvalid_cap;

    assign send_full  = (send_lvl == LVL_FULL);
    assign send_empty = (send_lvl == '0);
    assign send_val   = !send_empty;
    assign send_pop   = send_val && send_rdy;
    assign send_msg   = send_empty ? '0 : send_mem[send_rd];

    always_ff @(posedge clk) begin
        // NOTE: FIFO storage is not reset; the level counter alone decides what is valid.
        if (send_push) send_mem[send_wr] <= payload;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            send_wr  <= '0;
            send_rd  <= '0;
            send_lvl <= '0;
        end else begin
            if (send_push) send_wr <= send_wr + PTR_ONE;
            if (send_pop)  send_rd <= send_rd + PTR_ONE;
            case ({send_push, send_pop})
                2'b10:   send_lvl <= send_lvl + LVL_ONE;
                2'b01:   send_lvl <= send_lvl - LVL_ONE;
                default: send_lvl <= send_lvl;
            endcase
        end
    end

    // recv_rdy stays low through reset and comes up on the first cycle after it.
    always_ff @(posedge clk) begin
        if (reset) rdy_en <= 1'b0;
        else       rdy_en <= 1'b1;
    end

    assign resp_full  = (resp_lvl == LVL_FULL);
    assign resp_empty = (resp_lvl == '0);
    assign recv_rdy   = rdy_en && !resp_full;
    assign resp_push  = recv_val && recv_rdy;
    assign resp_head  = resp_empty ? '0 : resp_mem[resp_rd];

    always_ff @(posedge clk) begin
        if (resp_push) resp_mem[resp_wr] <= recv_msg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_wr  <= '0;
            resp_rd  <= '0;
            resp_lvl <= '0;
        end else begin
            if (resp_push) resp_wr <= resp_wr + PTR_ONE;
            if (resp_pop)  resp_rd <= resp_rd + PTR_ONE;
            case ({resp_push, resp_pop})
                2'b10:   resp_lvl <= resp_lvl + LVL_ONE;
                2'b01:   resp_lvl <= resp_lvl - LVL_ONE;
                default: resp_lvl <= resp_lvl;
            endcase
        end
    end

`ifdef SPI_MINION_PARITY_EN
    logic parity_q;
    logic overflow, frame_err;

    assign overflow  = frame_ok && wflag && send_full;
    assign frame_err = frame_end && (bit_cnt != FRAME_BITS);

    always_ff @(posedge clk) begin
        if (reset)                      parity_q <= 1'b0;
        else if (overflow || frame_err) parity_q <= 1'b1;
    end

    assign parity = parity_q;
`else
    assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_spi_minion_packet_adapter.sv
// Self-checking bench for spi_minion_packet_adapter: directed test-plan steps followed by
// randomized frames, all checked against a queue-based model of the adapter's behaviour.
module tb_spi_minion_packet_adapter;

    localparam int BW    = 32;
    localparam int DEPTH = 2;
    localparam int FW    = BW + 2;
    localparam int HALF  = 6;

`ifdef SPI_MINION_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          spi_cs, spi_sclk, spi_mosi, spi_miso;
    logic [BW-1:0] send_msg, recv_msg;
    logic          send_val, send_rdy, recv_val, recv_rdy, parity;

    spi_minion_packet_adapter #(.BIT_WIDTH(BW), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .spi_cs   (spi_cs),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .send_msg (send_msg),
        .send_val (send_val),
        .send_rdy (send_rdy),
        .recv_msg (recv_msg),
        .recv_val (recv_val),
        .recv_rdy (recv_rdy),
        .parity   (parity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: what each FIFO holds and whether the error flag should be set.
    logic [BW-1:0] sq[$];
    logic [BW-1:0] rq[$];
    bit            exp_par = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bits the master should see on MISO: space, rvalid, then the response head (0 if none).
    function automatic logic [63:0] exp_tx();
        logic [BW-1:0] head;
        head = (rq.size() > 0) ? rq[0] : '0;
        return {30'b0, (sq.size() < DEPTH), (rq.size() > 0), head};
    endfunction

    function automatic void model_end(input int nbits, input logic [63:0] tx, input bit rvalid_start);
        if (nbits == FW) begin
            if (tx[FW-1]) begin
                if (sq.size() < DEPTH) sq.push_back(tx[BW-1:0]);
                else if (PAR_EN) exp_par = 1'b1;
            end
            if (tx[FW-2] && rvalid_start) void'(rq.pop_front());
        end else if (PAR_EN) begin
            exp_par = 1'b1;
        end
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_send_val"}, 64'(send_val), 64'(sq.size() > 0));
        check({tag, "_send_msg"}, 64'(send_msg), (sq.size() > 0) ? 64'(sq[0]) : 64'h0);
        check({tag, "_parity"},   64'(parity),   64'(exp_par));
        check({tag, "_recv_rdy"}, 64'(recv_rdy), 64'(rq.size() < DEPTH));
    endtask

    // Clocks nbits mode-0 bits, MSB first; MISO is sampled just before each rising edge.
    task automatic send_bits(input int nbits, input logic [63:0] tx, output logic [63:0] rx);
        rx = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_mosi = tx[i];
            cyc(HALF);
            rx[i]    = spi_miso;
            spi_sclk = 1'b1;
            cyc(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input int nbits, input logic [63:0] tx, output logic [63:0] rx);
        spi_cs = 1'b0;
        cyc(HALF);
        send_bits(nbits, tx, rx);
        cyc(HALF);
    endtask

    task automatic frame(input int nbits, input logic [63:0] tx, input string tag);
        logic [63:0] exp, rx;
        bit          rv;
        exp = exp_tx();
        rv  = (rq.size() > 0);
        run_frame(nbits, tx, rx);
        check({tag, "_miso"}, rx, exp >> (FW - nbits));
        spi_cs = 1'b1;
        cyc(HALF);
        model_end(nbits, tx, rv);
        check_outputs(tag);
    endtask

    task automatic push_resp(input logic [BW-1:0] data, input string tag);
        check({tag, "_rdy"}, 64'(recv_rdy), 64'(rq.size() < DEPTH));
        recv_msg = data;
        recv_val = 1'b1;
        cyc(1);
        recv_val = 1'b0;
        if (rq.size() < DEPTH) rq.push_back(data);
    endtask

    task automatic drain(input string tag);
        while (sq.size() > 0) begin
            check({tag, "_val"}, 64'(send_val), 64'h1);
            check({tag, "_msg"}, 64'(send_msg), 64'(sq[0]));
            send_rdy = 1'b1;
            cyc(1);
            send_rdy = 1'b0;
            void'(sq.pop_front());
        end
        check({tag, "_empty"}, 64'(send_val), 64'h0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        cyc(n);
        reset = 1'b0;
        sq.delete();
        rq.delete();
        exp_par = 1'b0;
    endtask

    initial begin
        logic [63:0]   rx, exp;
        logic [BW-1:0] data;
        int            pulses;
        int            nbits;

        reset    = 1'b1;
        spi_cs   = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        send_rdy = 1'b0;
        recv_val = 1'b0;
        recv_msg = '0;
        cyc(4);

        // Reset values, then recv_rdy rising after release.
        check("rst_send_val", 64'(send_val), 64'h0);
        check("rst_send_msg", 64'(send_msg), 64'h0);
        check("rst_miso",     64'(spi_miso), 64'h0);
        check("rst_parity",   64'(parity),   64'h0);
        check("rst_recv_rdy", 64'(recv_rdy), 64'h0);
        reset = 1'b0;
        cyc(2);
        check("post_rst_recv_rdy", 64'(recv_rdy), 64'h1);
        cyc(4);

        // Write 0xDEADBEEF with latency check around the cs rise.
        exp = exp_tx();
        run_frame(FW, {30'b0, 2'b10, 32'hDEADBEEF}, rx);
        check("wr1_miso", rx, exp);
        spi_cs = 1'b1;
        cyc(2);
        check("wr1_early_val", 64'(send_val), 64'h0);
        cyc(2);
        model_end(FW, {30'b0, 2'b10, 32'hDEADBEEF}, 1'b0);
        check_outputs("wr1");
        cyc(2);
        drain("wr1_drain");

        // Response read-back.
        push_resp(32'h12345678, "rsp_push");
        cyc(2);
        frame(FW, {30'b0, 2'b01, 32'h0}, "rd1");
        frame(FW, {30'b0, 2'b00, 32'h0}, "rd1_after");

        // Overflow: three writes with send_rdy held low.
        frame(FW, {30'b0, 2'b10, 32'h1}, "ovf1");
        frame(FW, {30'b0, 2'b10, 32'h2}, "ovf2");
        frame(FW, {30'b0, 2'b10, 32'h3}, "ovf3");
        drain("ovf_drain");

        // Short frame after a fresh reset so the sticky flag starts clear.
        do_reset(3);
        cyc(4);
        frame(20, 64'h000C_5A5A, "short");

        // Reset in the middle of a write frame while cs stays low.
        do_reset(3);
        cyc(4);
        spi_cs = 1'b0;
        cyc(HALF);
        send_bits(10, 64'h2DE, rx);
        do_reset(3);
        cyc(2);
        check_outputs("midrst");
        send_bits(FW, {30'b0, 2'b10, 32'hCAFEF00D}, rx);
        cyc(HALF);
        spi_cs = 1'b1;
        cyc(HALF + 2);
        check_outputs("ignored");
        frame(FW, {30'b0, 2'b10, 32'h0BADC0DE}, "after_rst");
        drain("after_rst_drain");

        // Response FIFO full: held push waits for the pop at frame end.
        push_resp(32'hA0A0A0A0, "full_a");
        push_resp(32'hB1B1B1B1, "full_b");
        recv_msg = 32'hC2C2C2C2;
        recv_val = 1'b1;
        cyc(2);
        check("full_rdy_low", 64'(recv_rdy), 64'h0);
        exp = exp_tx();
        run_frame(FW, {30'b0, 2'b01, 32'h0}, rx);
        check("full_rd_miso", rx, exp);
        spi_cs = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (recv_rdy) pulses++;
        end
        recv_val = 1'b0;
        void'(rq.pop_front());
        rq.push_back(32'hC2C2C2C2);
        check("full_rdy_pulses", 64'(pulses), 64'h1);
        check_outputs("full_refill");
        frame(FW, {30'b0, 2'b01, 32'h0}, "full_rd_b");
        frame(FW, {30'b0, 2'b01, 32'h0}, "full_rd_c");
        frame(FW, {30'b0, 2'b00, 32'h0}, "full_rd_none");

        // Randomized traffic.
        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(1, 0) == 1) begin
                data = $urandom();
                push_resp(data, "rnd_push");
            end
            if ($urandom_range(7, 0) == 0) begin
                nbits = $urandom_range(33, 10);
                frame(nbits, 64'($urandom()), "rnd_short");
            end else begin
                data = $urandom();
                frame(FW, {30'b0, 1'($urandom()), 1'($urandom()), data}, "rnd_frame");
            end
            if ($urandom_range(2, 0) == 0) drain("rnd_drain");
        end
        drain("final_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
